// File: rtl/sce_ram_ctrl.sv
// rtl/sce_ram_ctrl.sv - SCE engine to single-port crypto SRAM controller with credit-checked read FIFO and scrub sequencer
module sce_ram_ctrl #(
  parameter int              AW           = 10,
  parameter int              DW           = 36,
  parameter int              RSP_DEPTH    = 4,
  parameter logic [DW-1:0]   CLR_VAL      = '0,
  parameter bit              CLR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [DW-1:0] req_wmask,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          ram_cen,
  output logic          ram_gwen,
  output logic [DW-1:0] ram_wen,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  input  logic [DW-1:0] ram_q
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 3);
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t        state, state_nx;
  logic          boot_pend;
  logic          done_q;
  logic          sweep;
  logic [AW-1:0] clr_cnt;
  logic          rd_s1, rd_s2;
  logic [DW-1:0] fifo_mem [RSP_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] occ;
  logic          req_fire, rd_fire, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits cover FIFO entries plus both read pipeline stages, so a push never overflows.
  assign occ       = fifo_cnt + CW'(rd_s1) + CW'(rd_s2);
  assign req_ready = !clr_busy && !clr_start && (req_we || (occ < CW'(RSP_DEPTH)));
  assign req_fire  = req_valid && req_ready;
  assign rd_fire   = req_fire && !req_we;
  assign push      = rd_s2;
  assign rsp_valid = (fifo_cnt != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = fifo_mem[rd_ptr];
  assign clr_done  = done_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (clr_start || boot_pend) state_nx = SWEEP;
      SWEEP:   if (clr_cnt == LAST_ADDR)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sweep    = (state == SWEEP);
    clr_busy = sweep;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      boot_pend <= CLR_ON_RESET;
      done_q    <= 1'b0;
      clr_cnt   <= '0;
    end else begin
      boot_pend <= 1'b0;
      done_q    <= sweep && (clr_cnt == LAST_ADDR);
      if (!sweep && state_nx == SWEEP)         clr_cnt <= '0;
      else if (sweep && clr_cnt != LAST_ADDR)  clr_cnt <= clr_cnt + AW'(1);
    end
  end

  // Scrub and request cycles never coincide: req_ready is low throughout SWEEP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ram_cen  <= 1'b1;
      ram_gwen <= 1'b1;
      ram_wen  <= '1;
      ram_a    <= '0;
      ram_d    <= '0;
    end else if (sweep) begin
      ram_cen  <= 1'b0;
      ram_gwen <= 1'b0;
      ram_wen  <= '0;
      ram_a    <= clr_cnt;
      ram_d    <= CLR_VAL;
    end else if (req_fire) begin
      ram_cen  <= 1'b0;
      ram_gwen <= !req_we;
      ram_wen  <= req_we ? ~req_wmask : '1;
      ram_a    <= req_addr;
      if (req_we) ram_d <= req_wdata;
    end else begin
      ram_cen  <= 1'b1;
      ram_gwen <= 1'b1;
      ram_wen  <= '1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_s1    <= 1'b0;
      rd_s2    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      rd_s1 <= rd_fire;
      rd_s2 <= rd_s1;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_q;
  end

endmodule
